sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Parameters
REQ-001 The module SHALL have parameter RD_LAT, default 2, meaning the number of clk rising edges from the edge that raises mem_oe to the edge that captures mem_dout.
REQ-002 The module SHALL have parameter REFRESH_INTERVAL, default 64, meaning the maximum number of consecutive granted slots before one idle slot is forced.
REQ-003 The module SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive slots a pending CPU request can lose to video before the CPU takes priority.

Interface
REQ-004 clk  in  1  8 MHz chipset clock; one clk cycle = one SDRAM slot; sole clock of the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU request level; held high until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-008 cpu_addr  in  24  word address; sampled at grant.
REQ-009 cpu_ds  in  2  byte strobes {upper, lower}; sampled at grant.
REQ-010 cpu_din  in  16  write data; sampled at grant.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 cpu_dout  out  16  read data; valid while cpu_ack is high after a read.
REQ-013 vid_req  in  1  video read request level; held high until vid_ack.
REQ-014 vid_addr  in  24  video word address; sampled at grant.
REQ-015 vid_ack  out  1  one-cycle pulse; vid_dout is valid in that cycle.
REQ-016 vid_dout  out  16  video read data.
REQ-017 mem_oe, mem_we  out  1 each  registered read/write strobes to the SDRAM controller; each is high for exactly one slot per grant.
REQ-018 mem_addr  out  24  registered address to the controller.
REQ-019 mem_ds  out  2  registered byte strobes to the controller; 2'b11 for video reads.
REQ-020 mem_din  out  16  registered write data to the controller.
REQ-021 mem_dout  in  16  read data from the controller.

Function
REQ-022 At each clk edge the arbiter SHALL grant at most one port; a grant SHALL register mem_* so that they hold for the following slot only. In all other slots, mem_oe and mem_we SHALL be 0.
REQ-023 Grant priority SHALL be: forced idle slot, then CPU if its starvation counter equals MAX_WAIT, then video, then CPU.
REQ-024 A port SHALL be busy from its grant edge through the edge that ends its ack cycle. A busy port SHALL NOT be granted, including at the edge that ends its ack cycle.
REQ-025 CPU write: cpu_ack SHALL be high in the same slot that mem_we is high.
REQ-026 Read, either port: mem_dout SHALL be captured into cpu_dout or vid_dout at the RD_LAT-th edge after the grant edge. The matching ack SHALL be high during the following cycle.
REQ-027 A shift register of depth RD_LAT SHALL carry a {valid, port} tag per read slot. This allows the video and CPU reads to overlap in flight, with at most one outstanding read per port.
REQ-028 cpu_dout and vid_dout SHALL hold their values between captures.
REQ-029 Starvation counter (3 bits min) SHALL increment at each edge where cpu_req is high, the CPU is not busy, and the CPU is not granted. It SHALL clear when the CPU is granted or cpu_req is low, and SHALL saturate at MAX_WAIT.
REQ-030 Refresh counter SHALL increment on each granted slot and clear on each slot with no grant. When it reaches REFRESH_INTERVAL-1, the next slot SHALL be idle regardless of requests, and the counter SHALL then clear.
REQ-031 When a forced idle slot and requests coincide, the requests SHALL wait; a forced idle slot SHALL NOT increment the starvation counter.
REQ-032 A request deasserted before its grant SHALL be dropped silently. Deasserting a request after its grant SHALL NOT cancel the access or its ack.

Reset
REQ-033 While reset is high at an edge, all outputs SHALL go to 0: mem_*, cpu_ack, vid_ack, cpu_dout, vid_dout = 16'h0000.
REQ-034 While reset is high, all counters, busy flags and in-flight tags SHALL clear. Reads in flight at reset SHALL produce no ack.
REQ-035 The first grant SHALL be possible at the first edge with reset low.

Verification
REQ-036 Scenario: CPU write addr=24'h001234, ds=2'b01, din=16'hBEEF, idle bus -> mem_we=1, mem_addr=24'h001234, mem_ds=2'b01, mem_din=16'hBEEF and cpu_ack=1 for one slot, then mem_we=0.
REQ-037 Scenario: CPU read addr=24'h000010 with mem_dout driven to 16'hA5A5 -> mem_oe is high for one slot; cpu_dout=16'hA5A5 and cpu_ack=1 in the slot RD_LAT edges after the grant edge.
REQ-038 Scenario: vid_req and cpu_req held continuously, with video re-requesting immediately after each ack -> the CPU is granted no later than the slot after MAX_WAIT (4) lost slots.
REQ-039 Scenario: both ports requesting back-to-back for 200 slots -> no run of granted slots exceeds 63 (REFRESH_INTERVAL-1) without an idle slot with mem_oe=mem_we=0.
REQ-040 Scenario: video read granted, then reset asserted for one cycle at the next edge -> all outputs are 0, vid_ack is never asserted for that read, and a new vid_req is granted at the first edge after reset.
REQ-041 Scenario: overlapping video and CPU reads (video granted at slot N, CPU at slot N+1) with mem_dout=16'h1111 then 16'h2222 -> vid_dout=16'h1111 and cpu_dout=16'h2222, each with its own one-cycle ack.

Source files
------------

// File: rtl/sdram_arb.sv
// sdram_arb: slot arbiter sharing one SDRAM controller between a CPU port
// (read/write) and a video port (read only). One clk cycle is one SDRAM slot.
// Reads are tracked by a {valid, port} tag pipeline so a video read and a
// CPU read can be in flight at the same time.
module sdram_arb #(
    parameter int RD_LAT           = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int MAX_WAIT         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_din,
    output logic        cpu_ack,
    output logic [15:0] cpu_dout,
    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_dout,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam int RW     = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int SW_MIN = $clog2(MAX_WAIT + 1);
    localparam int SW     = (SW_MIN > 3) ? SW_MIN : 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_VID  = 2'd2
    } gnt_e;

    // Registered memory-side strobes and fields
    logic              mem_oe_q,   mem_oe_d;
    logic              mem_we_q,   mem_we_d;
    logic [23:0]       mem_addr_q, mem_addr_d;
    logic [1:0]        mem_ds_q,   mem_ds_d;
    logic [15:0]       mem_din_q,  mem_din_d;

    // Port completion state
    logic              cpu_ack_q,  cpu_ack_d;
    logic              vid_ack_q,  vid_ack_d;
    logic [15:0]       cpu_dout_q, cpu_dout_d;
    logic [15:0]       vid_dout_q, vid_dout_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic              vid_busy_q, vid_busy_d;

    // Read tag pipeline: stage i is valid during the (i+1)-th slot after grant
    logic [RD_LAT-1:0] tag_vld_q,  tag_vld_d;
    logic [RD_LAT-1:0] tag_vid_q,  tag_vid_d;

    // Fairness and refresh counters
    logic [SW-1:0]     starve_q,   starve_d;
    logic [RW-1:0]     refresh_q,  refresh_d;

    // Grant decision (combinational, consumed by the next-state logic)
    gnt_e              gnt;
    logic              force_idle;
    logic              cpu_can;
    logic              vid_can;
    logic              starved;
    logic              cap_vld;
    logic              cap_vid;

    // Pick at most one port for this edge in priority order
    always_comb begin
        force_idle = (refresh_q == RW'(REFRESH_INTERVAL - 1));
        cpu_can    = cpu_req && !cpu_busy_q;
        vid_can    = vid_req && !vid_busy_q;
        starved    = (starve_q == SW'(MAX_WAIT));
        gnt        = GNT_NONE;
        if (!force_idle) begin
            if (cpu_can && starved) begin
                gnt = GNT_CPU;
            end else if (vid_can) begin
                gnt = GNT_VID;
            end else if (cpu_can) begin
                gnt = GNT_CPU;
            end
        end
    end

    // Next state for strobes, tags, acks, read data, busy flags and counters
    always_comb begin
        // Strobes last exactly one slot; the address/data fields simply hold.
        mem_oe_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_ds_d   = mem_ds_q;
        mem_din_d  = mem_din_q;

        case (gnt)
            GNT_CPU: begin
                mem_oe_d   = !cpu_we;
                mem_we_d   = cpu_we;
                mem_addr_d = cpu_addr;
                mem_ds_d   = cpu_ds;
                mem_din_d  = cpu_din;
            end
            GNT_VID: begin
                mem_oe_d   = 1'b1;
                mem_addr_d = vid_addr;
                mem_ds_d   = 2'b11;
            end
            default: begin
            end
        endcase

        // Every read slot enters the tag pipeline; writes never do.
        tag_vld_d    = '0;
        tag_vid_d    = '0;
        tag_vld_d[0] = (gnt == GNT_VID) || ((gnt == GNT_CPU) && !cpu_we);
        tag_vid_d[0] = (gnt == GNT_VID);
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_vid_d[i] = tag_vid_q[i-1];
        end

        // The last tag stage marks the edge where mem_dout is captured.
        cap_vld = tag_vld_q[RD_LAT-1];
        cap_vid = tag_vid_q[RD_LAT-1];

        // A CPU write completes in its own strobe slot; reads ack after capture.
        cpu_ack_d  = ((gnt == GNT_CPU) && cpu_we) || (cap_vld && !cap_vid);
        vid_ack_d  = cap_vld && cap_vid;
        cpu_dout_d = (cap_vld && !cap_vid) ? mem_dout : cpu_dout_q;
        vid_dout_d = (cap_vld &&  cap_vid) ? mem_dout : vid_dout_q;

        // Busy spans grant edge through the edge that ends the ack cycle.
        cpu_busy_d = (gnt == GNT_CPU) ? 1'b1 : (cpu_ack_q ? 1'b0 : cpu_busy_q);
        vid_busy_d = (gnt == GNT_VID) ? 1'b1 : (vid_ack_q ? 1'b0 : vid_busy_q);

        // Count slots the CPU could have used but lost; forced idles don't count.
        starve_d = starve_q;
        if (!cpu_req || (gnt == GNT_CPU)) begin
            starve_d = '0;
        end else if (!cpu_busy_q && !force_idle && !starved) begin
            starve_d = starve_q + SW'(1);
        end

        // Consecutive granted slots; any empty slot (forced or not) restarts it.
        refresh_d = (gnt != GNT_NONE) ? (refresh_q + RW'(1)) : '0;
    end

    // State registers with synchronous reset that also drops in-flight reads
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_oe_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_ds_q   <= '0;
            mem_din_q  <= '0;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
            cpu_busy_q <= 1'b0;
            vid_busy_q <= 1'b0;
            tag_vld_q  <= '0;
            tag_vid_q  <= '0;
            starve_q   <= '0;
            refresh_q  <= '0;
        end else begin
            mem_oe_q   <= mem_oe_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_ds_q   <= mem_ds_d;
            mem_din_q  <= mem_din_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
            cpu_dout_q <= cpu_dout_d;
            vid_dout_q <= vid_dout_d;
            cpu_busy_q <= cpu_busy_d;
            vid_busy_q <= vid_busy_d;
            tag_vld_q  <= tag_vld_d;
            tag_vid_q  <= tag_vid_d;
            starve_q   <= starve_d;
            refresh_q  <= refresh_d;
        end
    end

    assign mem_oe   = mem_oe_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_ds   = mem_ds_q;
    assign mem_din  = mem_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign vid_ack  = vid_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign vid_dout = vid_dout_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: bench for sdram_arb. A small SDRAM model answers reads,
// every observed grant pushes its expected ack/data onto a per-port queue,
// and acks are popped and compared as they appear. A short refresh interval
// is used so that forced idle slots occur within a short run.
module tb_sdram_arb;

    localparam int RD_LAT   = 2;
    localparam int REF_INT  = 4;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [23:0] cpu_addr;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_din;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_dout;
    logic        mem_oe, mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    always #5 clk = ~clk;

    sdram_arb #(
        .RD_LAT(RD_LAT),
        .REFRESH_INTERVAL(REF_INT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ds(mem_ds),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    typedef struct {
        int          due;
        bit          wr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          at;
        logic [15:0] data;
    } rd_t;

    typedef struct {
        bit          is_vid;
        bit          we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
        bit          preset;
        logic [15:0] rdata;
        int          exp_lat;
        logic [15:0] exp_dout;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        cpu_q[$];
    exp_t        vid_q[$];
    rd_t         rdq[$];
    logic [15:0] mem_model [logic [23:0]];
    logic [15:0] cpu_dout_exp = 16'h0;
    logic [15:0] vid_dout_exp = 16'h0;
    bit          cpu_busy_b = 0, vid_busy_b = 0;
    bit          cpu_ack_prev = 0, vid_ack_prev = 0;
    bit          cpu_rereq = 0, vid_rereq = 0;
    int          run_b = 0, lost_b = 0, forced_seen = 0;
    int          cpu_grants = 0, vid_grants = 0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rd_model(input logic [23:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[15:0] ^ 16'hC3C3;
    endfunction

    function automatic void model_wr(input logic [23:0] a, input logic [1:0] ds, input logic [15:0] d);
        logic [15:0] o;
        o = rd_model(a);
        if (ds[0]) o[7:0]  = d[7:0];
        if (ds[1]) o[15:8] = d[15:8];
        mem_model[a] = o;
    endfunction

    task automatic next_cpu();
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = 24'($urandom_range(0, 15));
        cpu_ds   = 2'($urandom_range(1, 3));
        cpu_din  = 16'($urandom);
    endtask

    // One slot: advance past the edge, check everything the DUT produced,
    // update the bench's own view, then drive the memory model's read data.
    task automatic tick();
        exp_t        e;
        logic [15:0] d;
        bit          gnt, gc, gv, exp_now;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            chk("reset_zero", {mem_oe, mem_we, mem_addr, mem_ds, mem_din,
                               cpu_ack, vid_ack, cpu_dout, vid_dout}, '0);
            cpu_q.delete(); vid_q.delete(); rdq.delete();
            cpu_dout_exp = 16'h0; vid_dout_exp = 16'h0;
            cpu_busy_b = 0; vid_busy_b = 0; cpu_ack_prev = 0; vid_ack_prev = 0;
            run_b = 0; lost_b = 0;
            mem_dout = 16'hDEAD;
            return;
        end
        gnt = mem_oe | mem_we;
        gv  = gnt && mem_addr[23];
        gc  = gnt && !mem_addr[23];
        chk("oe_we_exclusive", mem_oe & mem_we, 1'b0);

        if (run_b == REF_INT - 1) begin
            chk("refresh_idle", gnt, 1'b0);
            forced_seen++;
        end
        run_b = gnt ? run_b + 1 : 0;

        if (gc || !cpu_req) begin
            lost_b = 0;
        end else if (gv && !cpu_busy_b) begin
            lost_b++;
            chk("cpu_starve", lost_b > MAX_WAIT, 1'b0);
        end

        if (gc) begin
            cpu_grants++;
            chk("cpu_grant_req", cpu_req, 1'b1);
            chk("cpu_grant_busy", cpu_busy_b, 1'b0);
            chk("cpu_grant_we", mem_we, cpu_we);
            chk("cpu_grant_addr", mem_addr, cpu_addr);
            chk("cpu_grant_ds", mem_ds, cpu_ds);
            if (cpu_we) begin
                chk("cpu_grant_din", mem_din, cpu_din);
                model_wr(cpu_addr, cpu_ds, cpu_din);
                cpu_q.push_back('{cyc, 1'b1, 16'h0});
            end else begin
                d = rd_model(cpu_addr);
                cpu_q.push_back('{cyc + RD_LAT, 1'b0, d});
                rdq.push_back('{cyc + RD_LAT - 1, d});
            end
        end
        if (gv) begin
            vid_grants++;
            chk("vid_grant_req", vid_req, 1'b1);
            chk("vid_grant_busy", vid_busy_b, 1'b0);
            chk("vid_grant_oe", mem_oe, 1'b1);
            chk("vid_grant_addr", mem_addr, vid_addr);
            chk("vid_grant_ds", mem_ds, 2'b11);
            d = rd_model(vid_addr);
            vid_q.push_back('{cyc + RD_LAT, 1'b0, d});
            rdq.push_back('{cyc + RD_LAT - 1, d});
        end

        if (cpu_ack_prev) cpu_busy_b = 0;
        if (gc) cpu_busy_b = 1;
        if (vid_ack_prev) vid_busy_b = 0;
        if (gv) vid_busy_b = 1;

        while (cpu_q.size() > 0 && cpu_q[0].due < cyc) void'(cpu_q.pop_front());
        exp_now = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        chk("cpu_ack", cpu_ack, exp_now);
        if (exp_now) begin
            e = cpu_q.pop_front();
            if (!e.wr) cpu_dout_exp = e.data;
        end
        chk("cpu_dout", cpu_dout, cpu_dout_exp);

        while (vid_q.size() > 0 && vid_q[0].due < cyc) void'(vid_q.pop_front());
        exp_now = (vid_q.size() > 0) && (vid_q[0].due == cyc);
        chk("vid_ack", vid_ack, exp_now);
        if (exp_now) begin
            e = vid_q.pop_front();
            vid_dout_exp = e.data;
        end
        chk("vid_dout", vid_dout, vid_dout_exp);

        if (cpu_ack) begin
            if (cpu_rereq) next_cpu();
            else cpu_req = 1'b0;
        end
        if (vid_ack) begin
            if (vid_rereq) vid_addr = 24'h800000 | 24'($urandom_range(0, 16'hFFFF));
            else vid_req = 1'b0;
        end
        cpu_ack_prev = cpu_ack;
        vid_ack_prev = vid_ack;

        while (rdq.size() > 0 && rdq[0].at < cyc) void'(rdq.pop_front());
        if (rdq.size() > 0 && rdq[0].at == cyc) begin
            mem_dout = rdq[0].data;
            void'(rdq.pop_front());
        end else begin
            mem_dout = 16'hDEAD;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit got;
        if (v.preset) mem_model[v.addr] = v.rdata;
        if (v.is_vid) begin
            vid_addr = v.addr;
            vid_req  = 1'b1;
        end else begin
            cpu_we   = v.we;
            cpu_addr = v.addr;
            cpu_ds   = v.ds;
            cpu_din  = v.din;
            cpu_req  = 1'b1;
        end
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) chk($sformatf("vec%0d_grant_first_edge", idx), mem_oe | mem_we, 1'b1);
            got = v.is_vid ? vid_ack : cpu_ack;
        end
        chk($sformatf("vec%0d_ack_latency", idx), n, v.exp_lat);
        chk($sformatf("vec%0d_dout", idx), v.is_vid ? vid_dout : cpu_dout, v.exp_dout);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g, va, ca, n, nack;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = '0; cpu_din = '0;
        vid_req = 1'b0; vid_addr = 24'h800000;
        mem_dout = 16'hDEAD;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // is_vid, we, addr, ds, din, preset, rdata, exp_lat, exp_dout
        vecs[0] = '{1'b0, 1'b1, 24'h001234, 2'b01, 16'hBEEF, 1'b0, 16'h0000, 1,          16'h0000};
        vecs[1] = '{1'b0, 1'b0, 24'h000010, 2'b11, 16'h0000, 1'b1, 16'hA5A5, RD_LAT + 1, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b0, 24'h800020, 2'b11, 16'h0000, 1'b1, 16'h5A5A, RD_LAT + 1, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b1, 24'h000040, 2'b11, 16'h1234, 1'b0, 16'h0000, 1,          16'hA5A5};
        vecs[4] = '{1'b0, 1'b0, 24'h000040, 2'b11, 16'h0000, 1'b0, 16'h0000, RD_LAT + 1, 16'h1234};
        vecs[5] = '{1'b0, 1'b1, 24'h000040, 2'b10, 16'hABCD, 1'b0, 16'h0000, 1,          16'h1234};
        vecs[6] = '{1'b0, 1'b0, 24'h000040, 2'b11, 16'h0000, 1'b0, 16'h0000, RD_LAT + 1, 16'hAB34};
        vecs[7] = '{1'b1, 1'b0, 24'h8000FF, 2'b11, 16'h0000, 1'b1, 16'h0F0F, RD_LAT + 1, 16'h0F0F};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Overlapping reads: video wins the first slot, CPU takes the next.
        mem_model[24'h800100] = 16'h1111;
        mem_model[24'h000200] = 16'h2222;
        vid_addr = 24'h800100;
        cpu_we = 1'b0; cpu_addr = 24'h000200; cpu_ds = 2'b11;
        vid_req = 1'b1; cpu_req = 1'b1;
        tick();
        g = cyc;
        chk("ovl_vid_grant", {mem_oe, mem_addr}, {1'b1, 24'h800100});
        tick();
        chk("ovl_cpu_grant", {mem_oe, mem_addr}, {1'b1, 24'h000200});
        va = -1; ca = -1; n = 0;
        while ((va < 0 || ca < 0) && n < 12) begin
            tick();
            n++;
            if (vid_ack) begin va = cyc; chk("ovl_vid_dout", vid_dout, 16'h1111); end
            if (cpu_ack) begin ca = cyc; chk("ovl_cpu_dout", cpu_dout, 16'h2222); end
        end
        chk("ovl_vid_ack_cycle", va, g + RD_LAT);
        chk("ovl_cpu_ack_cycle", ca, g + 1 + RD_LAT);
        repeat (3) tick();

        // Reset one edge after a video grant: the read is abandoned, and the
        // still-held request is granted at the first edge with reset low.
        mem_model[24'h800300] = 16'h7777;
        vid_addr = 24'h800300;
        vid_req = 1'b1;
        tick();
        chk("rst_vid_grant", mem_oe, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_grant", {mem_oe, mem_addr}, {1'b1, 24'h800300});
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vid_ack) begin
                nack++;
                chk("post_reset_vid_dout", vid_dout, 16'h7777);
            end
        end
        chk("post_reset_vid_ack_count", nack, 1);

        // Both ports requesting back to back for 200 slots.
        forced_seen = 0;
        cpu_grants = 0;
        vid_grants = 0;
        cpu_rereq = 1; vid_rereq = 1;
        next_cpu();
        vid_addr = 24'h800400;
        cpu_req = 1'b1; vid_req = 1'b1;
        repeat (200) tick();
        cpu_rereq = 0; vid_rereq = 0;
        n = 0;
        while ((cpu_req || vid_req || cpu_q.size() > 0 || vid_q.size() > 0) && n < 30) begin
            tick();
            n++;
        end
        chk("stress_drained", {cpu_req, vid_req, 30'(cpu_q.size()), 30'(vid_q.size())}, '0);
        chk("stress_forced_idle_seen", forced_seen > 0, 1'b1);
        chk("stress_cpu_served", cpu_grants > 20, 1'b1);
        chk("stress_vid_served", vid_grants > 20, 1'b1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
